// File: rtl/pmem_multi_arbiter_pkg.sv
// Shared arbiter types: FSM state and operation enums, port-count limit and the
// round-robin pointer wrap helper.
package rv32i_types;

    localparam int ARB_MAX_REQ = 8;
    localparam int ARB_IDX_W   = $clog2(ARB_MAX_REQ);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        READ,
        WRITE,
        FINISH
    } arb_state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } arb_op_t;

    // Next round-robin start after serving idx; port 0 never takes part in the rotation.
    function automatic logic [ARB_IDX_W-1:0] arb_next_ptr(input logic [ARB_IDX_W-1:0] idx,
                                                          input int num_req);
        if (int'(idx) >= num_req - 1)
            return ARB_IDX_W'(1);
        return ARB_IDX_W'(int'(idx) + 1);
    endfunction

endpackage

// File: rtl/pmem_multi_arbiter_rr_picker.sv
// Combinational round-robin picker over ports 1..NUM_REQ-1, starting the scan at
// rr_ptr and wrapping from NUM_REQ-1 back to 1.
module rr_picker
    import rv32i_types::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0]   active,
    input  logic [ARB_IDX_W-1:0] rr_ptr,
    output logic [ARB_IDX_W-1:0] pick,
    output logic                 valid
);

    int idx;

    always_comb begin
        pick  = '0;
        valid = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ - 1; k++) begin
            idx = ((int'(rr_ptr) - 1 + k) % (NUM_REQ - 1)) + 1;
            if (!valid && active[idx]) begin
                valid = 1'b1;
                pick  = ARB_IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/pmem_multi_arbiter.sv
// Physical-memory arbiter: fixed-priority demand port 0, round-robin ports 1..N-1,
// broadcast read completion with same-line read merging.
// Optional performance counters are built when PMEM_ARB_PERF_EN is defined.
module pmem_multi_arbiter
    import rv32i_types::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int ADDR_W   = 32,
    parameter int LINE_W   = 256,
    parameter int OFFSET_W = 5
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_read,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*LINE_W-1:0] req_wdata,
    output logic [LINE_W-1:0]         req_rdata,
    output logic [NUM_REQ-1:0]        req_resp,
    output logic                      pmem_read,
    output logic                      pmem_write,
    output logic [ADDR_W-1:0]         pmem_address,
    output logic [LINE_W-1:0]         pmem_wdata,
    input  logic                      pmem_resp,
    input  logic [LINE_W-1:0]         pmem_rdata
`ifdef PMEM_ARB_PERF_EN
    ,
    output logic [NUM_REQ*32-1:0]     perf_grants,
    output logic [31:0]               perf_merges
`endif
);

    arb_state_t state, state_next;
    arb_op_t    op_q;

    logic [ARB_IDX_W-1:0]       grant_q, grant_idx, rr_ptr, pick;
    logic                       pick_valid, grant_fire;
    logic [NUM_REQ-1:0]         active, hit;
    logic                       sel_write;
    logic [ADDR_W-1:0]          sel_addr;
    logic [LINE_W-1:0]          sel_wdata;
    logic [ADDR_W-OFFSET_W-1:0] line_q;

    assign active     = req_read | req_write;
    assign grant_fire = active[0] | pick_valid;
    assign grant_idx  = active[0] ? '0 : pick;
    assign line_q     = pmem_address[ADDR_W-1:OFFSET_W];

    rr_picker #(.NUM_REQ(NUM_REQ)) u_rr_picker (
        .active (active),
        .rr_ptr (rr_ptr),
        .pick   (pick),
        .valid  (pick_valid)
    );

    // Granted-port mux plus the completion set: the grant itself and, for reads only,
    // every other port currently reading the latched line.
    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        hit       = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (j == int'(grant_q)) begin
                sel_write = req_write[j];
                sel_addr  = req_addr[j*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[j*LINE_W +: LINE_W];
                hit[j]    = 1'b1;
            end else if (op_q == OP_READ && req_read[j] &&
                         req_addr[j*ADDR_W+OFFSET_W +: ADDR_W-OFFSET_W] == line_q) begin
                hit[j] = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        req_resp   = '0;
        unique case (state)
            IDLE:        if (grant_fire) state_next = ISSUE;
            ISSUE:       state_next = sel_write ? WRITE : READ;
            READ, WRITE: if (pmem_resp) state_next = FINISH;
            FINISH: begin
                state_next = IDLE;
                req_resp   = hit;
            end
            default:     state_next = IDLE;
        endcase
    end

    // Strobes come from the state register only, never from requester inputs.
    assign pmem_read  = (state == READ);
    assign pmem_write = (state == WRITE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            rr_ptr       <= ARB_IDX_W'(1);
            grant_q      <= '0;
            op_q         <= OP_READ;
            pmem_address <= '0;
            pmem_wdata   <= '0;
            req_rdata    <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && grant_fire)
                grant_q <= grant_idx;
            if (state == ISSUE) begin
                pmem_address <= sel_addr;
                pmem_wdata   <= sel_wdata;
                op_q         <= sel_write ? OP_WRITE : OP_READ;
            end
            if (state == READ && pmem_resp)
                req_rdata <= pmem_rdata;
            if (state == FINISH && grant_q != '0)
                rr_ptr <= arb_next_ptr(grant_q, NUM_REQ);
        end
    end

`ifdef PMEM_ARB_PERF_EN
    localparam int CNT_W = ARB_IDX_W + 1;

    logic [CNT_W-1:0] merge_cnt;
    logic [32:0]      merge_sum;

    always_comb begin
        merge_cnt = '0;
        for (int j = 0; j < NUM_REQ; j++)
            if (hit[j] && j != int'(grant_q))
                merge_cnt = merge_cnt + CNT_W'(1);
    end

    assign merge_sum = {1'b0, perf_merges} + 33'(merge_cnt);

    // Saturating counters; merges only accumulate in FINISH, where hit is meaningful.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_grants <= '0;
            perf_merges <= '0;
        end else begin
            if (state == IDLE && grant_fire)
                for (int j = 0; j < NUM_REQ; j++)
                    if (j == int'(grant_idx) && perf_grants[j*32 +: 32] != '1)
                        perf_grants[j*32 +: 32] <= perf_grants[j*32 +: 32] + 32'd1;
            if (state == FINISH)
                perf_merges <= merge_sum[32] ? '1 : merge_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_pmem_multi_arbiter.sv
// Bench for pmem_multi_arbiter: directed scenarios then random traffic, all checked per
// cycle against a transaction-level model. Define PMEM_ARB_PERF_EN to also check counters.
module tb_pmem_multi_arbiter;

    localparam int NUM_REQ  = 3;
    localparam int ADDR_W   = 32;
    localparam int LINE_W   = 256;
    localparam int OFFSET_W = 5;

    logic                      clk = 1'b0;
    logic                      reset_n = 1'b0;
    logic [NUM_REQ-1:0]        req_read = '0;
    logic [NUM_REQ-1:0]        req_write = '0;
    logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
    logic [NUM_REQ*LINE_W-1:0] req_wdata = '0;
    logic [LINE_W-1:0]         req_rdata;
    logic [NUM_REQ-1:0]        req_resp;
    logic                      pmem_read, pmem_write;
    logic [ADDR_W-1:0]         pmem_address;
    logic [LINE_W-1:0]         pmem_wdata;
    logic                      pmem_resp = 1'b0;
    logic [LINE_W-1:0]         pmem_rdata = '0;
`ifdef PMEM_ARB_PERF_EN
    logic [NUM_REQ*32-1:0]     perf_grants;
    logic [31:0]               perf_merges;
`endif

    pmem_multi_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .LINE_W(LINE_W), .OFFSET_W(OFFSET_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_read(req_read), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rdata(req_rdata), .req_resp(req_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
`ifdef PMEM_ARB_PERF_EN
        , .perf_grants(perf_grants), .perf_merges(perf_merges)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Requester side: one outstanding transaction per port.
    bit                p_rd[NUM_REQ];
    bit                p_wr[NUM_REQ];
    bit                p_drop[NUM_REQ];
    bit                p_persist[NUM_REQ];
    logic [ADDR_W-1:0] p_addr[NUM_REQ];
    logic [LINE_W-1:0] p_data[NUM_REQ];

    // Transaction-level model of the arbiter and the pmem slave.
    bit                m_busy, m_fin, m_wr, rand_en;
    int                m_g, m_gcycle;
    int                m_rr = 1;
    logic [ADDR_W-1:0] m_addr, exp_addr = '0;
    logic [LINE_W-1:0] m_wdata, exp_wdata = '0, exp_rdata = '0;
    int                pm_cnt, pm_lat, n_pm_resp, n_rd_ops, n_wr_ops;
    int                fixed_lat = 4;
    int                resp_cycle[NUM_REQ];
    logic [LINE_W-1:0] resp_data[NUM_REQ];
    int                grant_log[$];
    int                req_cycle;

    task automatic checkOutput(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] randLine();
        logic [LINE_W-1:0] v;
        for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic int pickLat();
        return (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 4));
    endfunction

    task automatic applyStimulus(input int p, input bit wr, input bit rd,
                                 input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] data);
        p_wr[p] = wr;
        p_rd[p] = rd;
        p_addr[p] = addr;
        p_data[p] = data;
    endtask

    task automatic newRandomReq(input int p);
        int r;
        r = int'($urandom_range(0, 15));
        p_addr[p] = 32'h0000_4000 + ($urandom_range(0, 3) << 5) + $urandom_range(0, 31);
        p_data[p] = randLine();
        p_wr[p] = (r < 4);
        p_rd[p] = (r >= 4) || (r == 0);
    endtask

    task automatic driveInputs();
        for (int p = 0; p < NUM_REQ; p++) begin
            req_read[p] = p_rd[p];
            req_write[p] = p_wr[p];
            req_addr[p*ADDR_W +: ADDR_W] = p_addr[p];
            req_wdata[p*LINE_W +: LINE_W] = p_data[p];
        end
    endtask

    // One clock: drive requesters and pmem, compare every output, then advance the model.
    task automatic runCycle();
        logic [NUM_REQ-1:0] exp_resp;
        logic [LINE_W-1:0]  pm_val;
        bit strobe, fin, pm_r;
        int w, idx;
        @(posedge clk);
        #1;
        cyc++;
        for (int p = 0; p < NUM_REQ; p++) begin
            if (p_drop[p]) begin
                p_rd[p] = 1'b0;
                p_wr[p] = 1'b0;
                p_drop[p] = 1'b0;
            end else if (!p_rd[p] && !p_wr[p]) begin
                if (p_persist[p]) p_rd[p] = 1'b1;
                else if (rand_en && $urandom_range(0, (p == 0) ? 9 : 3) == 0) newRandomReq(p);
            end
        end
        strobe = m_busy && !m_fin && (cyc >= m_gcycle + 2);
        fin = m_busy && m_fin;
        pm_r = 1'b0;
        pm_val = randLine();
        if (strobe) begin
            if (cyc == m_gcycle + 2) begin
                if (m_wr) n_wr_ops++;
                else n_rd_ops++;
            end
            pm_cnt++;
            if (pm_cnt == pm_lat + 1) begin
                pm_r = 1'b1;
                if (!rand_en) pm_val = {8{32'hC0DE_0000 + n_pm_resp}};
                n_pm_resp++;
            end
        end
        driveInputs();
        pmem_resp = pm_r;
        pmem_rdata = pm_val;
        #1;
        exp_resp = '0;
        if (fin) begin
            exp_resp[m_g] = 1'b1;
            if (!m_wr)
                for (int j = 0; j < NUM_REQ; j++)
                    if (j != m_g && p_rd[j] && p_addr[j][ADDR_W-1:OFFSET_W] == m_addr[ADDR_W-1:OFFSET_W])
                        exp_resp[j] = 1'b1;
        end
        checkOutput("pmem_read", LINE_W'(pmem_read), LINE_W'(strobe && !m_wr));
        checkOutput("pmem_write", LINE_W'(pmem_write), LINE_W'(strobe && m_wr));
        checkOutput("req_resp", LINE_W'(req_resp), LINE_W'(exp_resp));
        checkOutput("pmem_address", LINE_W'(pmem_address), LINE_W'(exp_addr));
        checkOutput("pmem_wdata", pmem_wdata, exp_wdata);
        checkOutput("req_rdata", req_rdata, exp_rdata);
        if (fin) begin
            for (int j = 0; j < NUM_REQ; j++)
                if (exp_resp[j]) begin
                    p_drop[j] = 1'b1;
                    resp_cycle[j] = cyc;
                    resp_data[j] = exp_rdata;
                end
            if (m_g != 0) m_rr = (m_g == NUM_REQ - 1) ? 1 : m_g + 1;
            m_busy = 1'b0;
            m_fin = 1'b0;
        end else if (m_busy) begin
            if (cyc == m_gcycle + 1) begin
                exp_addr = m_addr;
                exp_wdata = m_wdata;
            end
            if (strobe && pm_r) begin
                m_fin = 1'b1;
                if (!m_wr) exp_rdata = pm_val;
            end
        end else begin
            w = -1;
            if (p_rd[0] || p_wr[0]) w = 0;
            else begin
                idx = m_rr;
                repeat (NUM_REQ - 1) begin
                    if (w < 0 && (p_rd[idx] || p_wr[idx])) w = idx;
                    idx = (idx == NUM_REQ - 1) ? 1 : idx + 1;
                end
            end
            if (w >= 0) begin
                m_busy = 1'b1;
                m_g = w;
                m_gcycle = cyc;
                m_wr = p_wr[w];
                m_addr = p_addr[w];
                m_wdata = p_data[w];
                pm_cnt = 0;
                pm_lat = pickLat();
                grant_log.push_back(w);
            end
        end
    endtask

    function automatic bit anyPending();
        bit a;
        a = m_busy;
        for (int p = 0; p < NUM_REQ; p++) a |= p_rd[p] | p_wr[p] | p_drop[p];
        return a;
    endfunction

    task automatic runUntilIdle(input int budget);
        int n;
        n = 0;
        while (anyPending() && n < budget) begin
            runCycle();
            n++;
        end
        if (anyPending()) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL drain_timeout cycle %0d: still busy after %0d cycles, expected idle", cyc, budget);
        end
    endtask

    initial begin
        int g0, n_rd0, n_wr0;
        logic [31:0] pg0, pm0;
        for (int p = 0; p < NUM_REQ; p++) resp_cycle[p] = -1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_pmem_read", LINE_W'(pmem_read), '0);
        checkOutput("reset_pmem_write", LINE_W'(pmem_write), '0);
        checkOutput("reset_req_resp", LINE_W'(req_resp), '0);
        checkOutput("reset_pmem_address", LINE_W'(pmem_address), '0);
        checkOutput("reset_req_rdata", req_rdata, '0);
        @(negedge clk);
        reset_n = 1'b1;

        // Demand port beats port 2; latency 4 gives a response 7 cycles after the request.
        $display("[TB] scenario: demand priority");
        applyStimulus(0, 1'b0, 1'b1, 32'h0000_1000, randLine());
        applyStimulus(2, 1'b0, 1'b1, 32'h0000_2000, randLine());
        req_cycle = cyc + 1;
        runUntilIdle(100);
        checkOutput("s1_port0_latency", LINE_W'(resp_cycle[0] - req_cycle), LINE_W'(7));
        checkOutput("s1_port2_latency", LINE_W'(resp_cycle[2] - req_cycle), LINE_W'(15));
        checkOutput("s1_port0_data", resp_data[0], {8{32'hC0DE_0000}});
        checkOutput("s1_port2_data", resp_data[2], {8{32'hC0DE_0001}});
        checkOutput("s1_first_grant", LINE_W'(grant_log[0]), LINE_W'(0));
        checkOutput("s1_second_grant", LINE_W'(grant_log[1]), LINE_W'(2));

        // Ports 1 and 2 both hammering: strict alternation.
        $display("[TB] scenario: round robin");
        g0 = grant_log.size();
        applyStimulus(1, 1'b0, 1'b1, 32'h0000_6000, randLine());
        applyStimulus(2, 1'b0, 1'b1, 32'h0000_6040, randLine());
        p_persist[1] = 1'b1;
        p_persist[2] = 1'b1;
        for (int n = 0; n < 200 && !(grant_log.size() >= g0 + 4 && !m_busy); n++) runCycle();
        checkOutput("s2_grant_count", LINE_W'(grant_log.size() >= g0 + 4), LINE_W'(1));
        if (grant_log.size() >= g0 + 4) begin
            checkOutput("s2_grant_a", LINE_W'(grant_log[g0]), LINE_W'(1));
            checkOutput("s2_grant_b", LINE_W'(grant_log[g0+1]), LINE_W'(2));
            checkOutput("s2_grant_c", LINE_W'(grant_log[g0+2]), LINE_W'(1));
            checkOutput("s2_grant_d", LINE_W'(grant_log[g0+3]), LINE_W'(2));
        end
        checkOutput("s2_rr_ptr", LINE_W'(m_rr), LINE_W'(1));
        p_persist[1] = 1'b0;
        p_persist[2] = 1'b0;
        runUntilIdle(100);

        // Same-line reads from ports 0 and 1 share one pmem read.
        $display("[TB] scenario: read merge");
        n_rd0 = n_rd_ops;
`ifdef PMEM_ARB_PERF_EN
        pg0 = perf_grants[31:0];
        pm0 = perf_merges;
`else
        pg0 = '0;
        pm0 = '0;
`endif
        applyStimulus(0, 1'b0, 1'b1, 32'h0000_1004, randLine());
        applyStimulus(1, 1'b0, 1'b1, 32'h0000_101C, randLine());
        runUntilIdle(100);
        checkOutput("s3_single_read", LINE_W'(n_rd_ops - n_rd0), LINE_W'(1));
        checkOutput("s3_same_cycle", LINE_W'(resp_cycle[1]), LINE_W'(resp_cycle[0]));
        checkOutput("s3_same_data", resp_data[1], resp_data[0]);
        checkOutput("s3_address", LINE_W'(exp_addr), LINE_W'(32'h0000_1004));
`ifdef PMEM_ARB_PERF_EN
        checkOutput("s3_perf_merges", LINE_W'(perf_merges - pm0), LINE_W'(1));
        checkOutput("s3_perf_grants0", LINE_W'(perf_grants[31:0] - pg0), LINE_W'(1));
`endif

        // Write ahead of a same-line read: no merge, separate read afterwards.
        $display("[TB] scenario: write before read");
        n_rd0 = n_rd_ops;
        n_wr0 = n_wr_ops;
        g0 = grant_log.size();
        applyStimulus(2, 1'b1, 1'b0, 32'h0000_3000, {32{8'hA5}});
        runCycle();
        applyStimulus(1, 1'b0, 1'b1, 32'h0000_3000, randLine());
        runUntilIdle(100);
        checkOutput("s4_writes", LINE_W'(n_wr_ops - n_wr0), LINE_W'(1));
        checkOutput("s4_reads", LINE_W'(n_rd_ops - n_rd0), LINE_W'(1));
        checkOutput("s4_first_grant", LINE_W'(grant_log[g0]), LINE_W'(2));
        checkOutput("s4_read_after_write", LINE_W'(resp_cycle[1] > resp_cycle[2]), LINE_W'(1));

        // Reset in the middle of a read.
        $display("[TB] scenario: reset mid-read");
        applyStimulus(1, 1'b0, 1'b1, 32'h0000_5000, randLine());
        for (int n = 0; n < 20 && !(m_busy && !m_fin && cyc >= m_gcycle + 2); n++) runCycle();
        #1;
        reset_n = 1'b0;
        pmem_resp = 1'b1;
        #1;
        checkOutput("rst_pmem_read", LINE_W'(pmem_read), '0);
        checkOutput("rst_req_resp", LINE_W'(req_resp), '0);
        checkOutput("rst_pmem_address", LINE_W'(pmem_address), '0);
        checkOutput("rst_req_rdata", req_rdata, '0);
`ifdef PMEM_ARB_PERF_EN
        checkOutput("rst_perf_merges", LINE_W'(perf_merges), '0);
`endif
        for (int p = 0; p < NUM_REQ; p++) begin
            p_rd[p] = 1'b0;
            p_wr[p] = 1'b0;
            p_drop[p] = 1'b0;
        end
        driveInputs();
        m_busy = 1'b0;
        m_fin = 1'b0;
        m_rr = 1;
        exp_addr = '0;
        exp_wdata = '0;
        exp_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        pmem_resp = 1'b0;
        reset_n = 1'b1;
        g0 = grant_log.size();
        applyStimulus(1, 1'b0, 1'b1, 32'h0000_7000, randLine());
        applyStimulus(2, 1'b0, 1'b1, 32'h0000_7100, randLine());
        runUntilIdle(100);
        checkOutput("rst_fresh_grant", LINE_W'(grant_log[g0]), LINE_W'(1));

        // Random traffic with random pmem latency.
        $display("[TB] scenario: random traffic");
        rand_en = 1'b1;
        fixed_lat = -1;
        repeat (2000) runCycle();
        rand_en = 1'b0;
        runUntilIdle(400);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pmem_multi_arbiter.md
Name: pmem_multi_arbiter

Overview:
- Generalised physical-memory arbiter that sits between NUM_REQ line-granular requesters and a single pmem port.
- Requesters include the L2 demand port, one or more prefetchers and a victim/writeback buffer.
- Port 0 is the demand port and has fixed top priority. Ports 1..NUM_REQ-1 share round-robin priority.
- Completed reads are broadcast, so every requester waiting on the same line gets a response in the same cycle (read merging).

Parameters:
- NUM_REQ, 3, number of requester ports (2..8); port 0 is demand.
- ADDR_W, 32, address width.
- LINE_W, 256, line/data width in bits.
- OFFSET_W, 5, line-offset bits ignored for address match (log2(LINE_W/8)).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req_read  in  NUM_REQ  per-port read request, held until that port's req_resp
- req_write  in  NUM_REQ  per-port write request, held until that port's req_resp
- req_addr  in  NUM_REQ*ADDR_W  packed per-port addresses, port i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*LINE_W  packed per-port write data
- req_rdata  out  LINE_W  shared read-data broadcast
- req_resp  out  NUM_REQ  one-cycle per-port completion pulse
- pmem_read  out  1  pmem read strobe
- pmem_write  out  1  pmem write strobe
- pmem_address  out  ADDR_W  registered pmem address
- pmem_wdata  out  LINE_W  registered pmem write data
- pmem_resp  in  1  pmem completion
- pmem_rdata  in  LINE_W  pmem read data

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE, rr_ptr=1.
  - Address, data and grant registers clear to 0.
  - All outputs go to 0 immediately, including mid-transaction.
  - pmem_resp is ignored while reset_n=0.
- States: IDLE, ISSUE, READ, WRITE, FINISH.
- IDLE:
  - A port is "active" if req_read|req_write is asserted.
  - If port 0 is active, grant port 0.
  - Otherwise grant the first active port scanning from rr_ptr upward, wrapping past NUM_REQ-1 to 1.
  - If no port is active, stay in IDLE.
- Simultaneous read and write on one port: write wins.
- ISSUE (1 cycle):
  - Latch the granted address, wdata, grant index and op type (read/write).
  - Go to WRITE if op is write, otherwise READ.
- READ / WRITE:
  - Drive pmem_read or pmem_write continuously from registered state (no combinational path from req_*).
  - In READ, load the rdata register every cycle pmem_resp=1.
  - Exit to FINISH on pmem_resp=1.
- FINISH (1 cycle):
  - req_resp[grant]=1.
  - For a read only, every other port j with req_read[j]=1 and req_addr[j][ADDR_W-1:OFFSET_W] equal to the latched line also gets req_resp[j]=1 (merge).
  - Writes never merge.
  - If the grant was nonzero, rr_ptr becomes grant+1, wrapping to 1. Port-0 grants leave rr_ptr unchanged.
  - Next state is IDLE.
- req_rdata holds the last read line until the next READ completes and is valid in FINISH.
- Minimum latency from request in IDLE to req_resp is pmem latency + 3 cycles.
- Requesters must drop their request in the cycle after req_resp. The mandatory FINISH→IDLE turnaround guarantees no double service.
- Reads and writes to the same line: no merging and no ordering beyond grant order. A write granted before a read to the same line completes first.
- Starvation: ports 1..N-1 are starvation-free among themselves. Port 0 can starve them; this is accepted.
- Request dropped before grant: ignored. Request dropped after ISSUE: the transaction still completes and its response pulse is harmless.

Optional Feature:
- Macro PMEM_ARB_PERF_EN.
- When defined, adds outputs perf_grants (NUM_REQ*32) and perf_merges (32). These are saturating counters of grants per port and of merged responses, cleared by reset_n.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package rv32i_types gets:
  - arb_state_t (enum of the five states).
  - arb_op_t (READ/WRITE).
  - Constant ARB_MAX_REQ=8.
- One sub-module, rr_picker, combinational: inputs are the active vector and rr_ptr; outputs are the grant index and a valid bit, covering ports 1..N-1 only. Port-0 override and all sequential logic stay in the top module.

Test Plan:
- Port 0 reads 0x1000 while port 2 reads 0x2000 in the same cycle, pmem latency 4 → port 0 is served first. req_resp[0] pulses 7 cycles after the request with req_rdata = pmem data; port 2 is served next.
- Ports 1 and 2 request continuously (NUM_REQ=3, port 0 idle) → grants alternate 1,2,1,2. rr_ptr ends at 1 after port 2 is served.
- Port 0 reads 0x1004 while port 1 reads 0x101C (same line) → a single pmem_read to 0x1004, with req_resp[0] and req_resp[1] in the same cycle and identical req_rdata.
- Port 2 writes 0x3000 with data 0xA5..A5 while port 1 reads 0x3000 → WRITE is issued first with pmem_wdata=0xA5..A5 and no merge. A separate READ follows and port 1 responds only after it.
- reset_n is dropped in READ with pmem_read=1 → pmem_read and req_resp go to 0 within the same cycle. After release, state is IDLE, rr_ptr=1, and a fresh request is served normally.
- With PMEM_ARB_PERF_EN defined, run scenario 3 → perf_merges=1 and perf_grants[0]=1.
